// File: rtl/clk_gen.sv
// ============================================================================
//  Module   : clk_gen
//  Purpose  : Programmable synchronous clock divider. Produces a registered,
//             glitch-free divided clock with near-50% duty cycle, plus
//             one-cycle rise/fall strobes in the system clock domain.
//  Ports    : clk_i        - system clock (rising edge)
//             rst_i        - synchronous active-high reset
//             en_i         - run enable
//             div_i        - requested divide ratio N (0 and 1 act as 2)
//             div_valid_i  - div_i is valid
//             div_ready_o  - no divider update pending
//             div_o        - divide ratio in effect (clamped)
//             clk_o        - divided clock, straight from a flop
//             clk_rise_o   - high in the first cycle clk_o reads 1
//             clk_fall_o   - high in the first cycle clk_o reads 0
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int DIV_DEFAULT = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 clk_o,
    output logic                 clk_rise_o,
    output logic                 clk_fall_o
);

    localparam logic [DIV_WIDTH-1:0] c_DIV_MIN   = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] c_ONE       = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] c_DIV_RESET =
        (DIV_DEFAULT < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DIV_DEFAULT);

    typedef enum logic [1:0] {
        IDLE_LOW = 2'd0,
        HIGH     = 2'd1,
        LOW      = 2'd2
    } state_t;

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < c_DIV_MIN) ? c_DIV_MIN : d;
    endfunction

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   pend_q, pend_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   clk_q, clk_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    logic                   w_start;
    logic [DIV_WIDTH-1:0]   w_div_eff;
    logic [DIV_WIDTH-1:0]   w_high_m1;
    logic [DIV_WIDTH-1:0]   w_low_m1;

    // Divider that a HIGH entry in this cycle would use. A pending value is
    // only visible once registered, so an accept in the same cycle as a rise
    // leaves that rise on the old divider.
    assign w_div_eff = pend_valid_q ? pend_q : div_q;

    // H-1 = ceil(N/2)-1 built as (N>>1) + N[0] - 1: never exceeds N, so no
    // overflow even at the all-ones ratio. N >= 2 keeps the result >= 0.
    assign w_high_m1 = (w_div_eff >> 1) + {{(DIV_WIDTH-1){1'b0}}, w_div_eff[0]} - c_ONE;

    // L-1 = floor(N/2)-1. div_q only changes at HIGH entry, so this is stable
    // for the whole period it is used in.
    assign w_low_m1 = (div_q >> 1) - c_ONE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE_LOW;
            cnt_q        <= '0;
            div_q        <= c_DIV_RESET;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            clk_q        <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clk_q        <= clk_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        clk_d        = clk_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        w_start      = 1'b0;

        case (state_q)
            IDLE_LOW: begin
                clk_d = 1'b0;
                if (en_i) begin
                    w_start = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    clk_d   = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = w_low_m1;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    // Period boundary: continue or park low.
                    if (en_i) begin
                        w_start = 1'b1;
                    end else begin
                        state_d = IDLE_LOW;
                    end
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                clk_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // HIGH entry: latch the new ratio (if any) and load the high count.
        if (w_start) begin
            state_d      = HIGH;
            clk_d        = 1'b1;
            rise_d       = 1'b1;
            cnt_d        = w_high_m1;
            div_d        = w_div_eff;
            pend_valid_d = 1'b0;
        end

        // Accept only while nothing is pending; start above cannot clear a
        // pending value in the same cycle it is accepted.
        if (div_valid_i && !pend_valid_q) begin
            pend_d       = clamp_div(div_i);
            pend_valid_d = 1'b1;
        end
    end

    assign div_ready_o = ~pend_valid_q;
    assign div_o       = div_q;
    assign clk_o       = clk_q;
    assign clk_rise_o  = rise_q;
    assign clk_fall_o  = fall_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_gen.sv
// ============================================================================
//  Module   : tb_clk_gen
//  Purpose  : Self-checking bench for clk_gen: vector table, directed corner
//             sequences and randomized stimulus against a period-position
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_gen;

    localparam int W       = 16;
    localparam int DEF_DIV = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div;
    logic         div_valid;
    logic         div_ready;
    logic [W-1:0] div_out;
    logic         clk_out;
    logic         rise;
    logic         fall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_gen #(.DIV_WIDTH(W), .DIV_DEFAULT(DEF_DIV)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .div_i       (div),
        .div_valid_i (div_valid),
        .div_ready_o (div_ready),
        .div_o       (div_out),
        .clk_o       (clk_out),
        .clk_rise_o  (rise),
        .clk_fall_o  (fall)
    );

    // Reference model: position within the current period (0..N-1), with
    // N and H fixed at the start of each period.
    bit m_running, m_pend, m_clk, m_rise, m_fall;
    int m_pos, m_N, m_H, m_div, m_pval;

    function automatic int clampv(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_edge();
        bit acc;
        acc = div_valid && !m_pend;
        if (rst) begin
            m_running = 0; m_pos = 0; m_clk = 0; m_rise = 0; m_fall = 0;
            m_div = clampv(DEF_DIV); m_pend = 0;
            return;
        end
        m_rise = 0;
        m_fall = 0;
        if (!m_running || m_pos == m_N - 1) begin
            if (en) begin
                if (m_pend) begin
                    m_div  = m_pval;
                    m_pend = 0;
                end
                m_N = m_div;
                m_H = (m_N + 1) / 2;
                m_pos = 0;
                m_running = 1;
                m_rise = 1;
            end else begin
                m_running = 0;
                m_pos = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == m_H) m_fall = 1;
        end
        m_clk = m_running && (m_pos < m_H);
        if (acc) begin
            m_pend = 1;
            m_pval = clampv(int'(div));
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit use_model);
        @(posedge clk);
        model_edge();
        #1;
        if (use_model) begin
            chk("clk_o",       32'(clk_out),   32'(m_clk));
            chk("clk_rise_o",  32'(rise),      32'(m_rise));
            chk("clk_fall_o",  32'(fall),      32'(m_fall));
            chk("div_ready_o", 32'(div_ready), 32'(!m_pend));
            chk("div_o",       32'(div_out),   32'(m_div));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1);
    endtask

    // Step until the model sits at position p of a period of length n.
    task automatic run_until(input int n, input int p);
        int k;
        for (k = 0; k < 5000; k++) begin
            if (m_running && m_N == n && m_pos == p) break;
            step(1);
        end
        checks++;
        if (k >= 5000) begin
            errors++;
            $display("FAIL timeout waiting for N=%0d pos=%0d: got pos %0d required %0d", n, p, m_pos, p);
        end
    endtask

    task automatic write_div(input int d);
        div = W'(d);
        div_valid = 1'b1;
        step(1);
        div_valid = 1'b0;
    endtask

    typedef struct {
        bit           rst;
        bit           en;
        bit           valid;
        logic [W-1:0] div;
        bit           clk;
        bit           rise;
        bit           fall;
        bit           rdy;
        int           dv;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst = 1'b1; en = 1'b0; div = '0; div_valid = 1'b0;

        //          rst en vld div    clk rise fall rdy div_o
        tbl[0]  = '{1, 0, 0, 16'd0,  0, 0, 0, 1, 1000};
        tbl[1]  = '{1, 0, 0, 16'd0,  0, 0, 0, 1, 1000};
        tbl[2]  = '{1, 0, 0, 16'd0,  0, 0, 0, 1, 1000};
        tbl[3]  = '{0, 0, 1, 16'd3,  0, 0, 0, 0, 1000};
        tbl[4]  = '{0, 1, 0, 16'd0,  1, 1, 0, 1, 3};
        tbl[5]  = '{0, 1, 0, 16'd0,  1, 0, 0, 1, 3};
        tbl[6]  = '{0, 1, 0, 16'd0,  0, 0, 1, 1, 3};
        tbl[7]  = '{0, 1, 0, 16'd0,  1, 1, 0, 1, 3};
        tbl[8]  = '{0, 0, 0, 16'd0,  1, 0, 0, 1, 3};
        tbl[9]  = '{0, 0, 0, 16'd0,  0, 0, 1, 1, 3};
        tbl[10] = '{0, 0, 0, 16'd0,  0, 0, 0, 1, 3};
        tbl[11] = '{0, 0, 1, 16'd0,  0, 0, 0, 0, 3};
        tbl[12] = '{0, 1, 0, 16'd0,  1, 1, 0, 1, 2};
        tbl[13] = '{0, 1, 0, 16'd0,  0, 0, 1, 1, 2};
        tbl[14] = '{0, 1, 0, 16'd0,  1, 1, 0, 1, 2};
        tbl[15] = '{1, 1, 0, 16'd0,  0, 0, 0, 1, 1000};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; en = tbl[i].en;
            div_valid = tbl[i].valid; div = tbl[i].div;
            step(0);
            chk($sformatf("tbl[%0d] clk_o", i),       32'(clk_out),   32'(tbl[i].clk));
            chk($sformatf("tbl[%0d] clk_rise_o", i),  32'(rise),      32'(tbl[i].rise));
            chk($sformatf("tbl[%0d] clk_fall_o", i),  32'(fall),      32'(tbl[i].fall));
            chk($sformatf("tbl[%0d] div_ready_o", i), 32'(div_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl[%0d] div_o", i),       32'(div_out),   32'(tbl[i].dv));
        end

        // Default 1000-cycle run from reset.
        rst = 1'b0; en = 1'b1; div_valid = 1'b0;
        run(2100);

        // Update accepted at cycle 200 of a 1000-cycle period.
        run_until(1000, 199);
        write_div(10);
        chk("ready low after accept", 32'(div_ready), 32'd0);
        run(1200);

        // Odd and clamped ratios, then back to the default ratio.
        write_div(3);
        run(40);
        write_div(0);
        run(20);
        write_div(1000);

        // Enable drop during the high phase: period completes, then parks.
        run_until(1000, 100);
        en = 1'b0;
        run(1100);
        chk("parked low", 32'(clk_out), 32'd0);
        en = 1'b1;
        step(1);
        chk("rise on re-enable", 32'(rise), 32'd1);

        // Reset mid-high with an update pending.
        run_until(1000, 50);
        write_div(7);
        rst = 1'b1;
        step(1);
        chk("reset mid-high clk_o", 32'(clk_out), 32'd0);
        chk("reset mid-high div_o", 32'(div_out), 32'd1000);
        rst = 1'b0;
        run(1100);

        // Largest ratio: high phase must be exactly 32768 cycles.
        write_div(65535);
        run_until(65535, 0);
        run(32770);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // Randomized stimulus.
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            div_valid = ($urandom_range(0, 3) == 0);
            div       = W'($urandom_range(0, 12));
            rst       = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0; div_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
